// File: rtl/rheed_frame_sched.sv
// RHEED frame scheduler: one pipeline start per camera frame, tracks crop results, recovers on timeout; stats under RHEED_SCHED_STATS_EN.
// Latency: START one cycle after frame_sof, frame_done one cycle after the last result; no backpressure, frame_sof while busy is dropped.
module rheed_frame_sched #(
  parameter int NUM_CROPS      = 5,
  parameter int COORD_W        = 11,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int RECOVER_CYCLES = 16,
  localparam int IDX_W = (NUM_CROPS > 1) ? $clog2(NUM_CROPS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cfg_wr_en,
  input  logic                         cfg_commit,
  input  logic                         frame_sof,
  input  logic                         res_valid,
  input  logic                         err_clear,
  input  logic [IDX_W-1:0]             cfg_wr_idx,
  input  logic [COORD_W-1:0]           cfg_wr_x,
  input  logic [COORD_W-1:0]           cfg_wr_y,
  input  logic [IDX_W-1:0]             res_idx,
  output logic [NUM_CROPS*COORD_W-1:0] crop_x0,
  output logic [NUM_CROPS*COORD_W-1:0] crop_y0,
  output logic                         pipe_ap_start,
  output logic                         pipe_rst,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         timeout_err,
  output logic [31:0]                  frames_started,
  output logic [31:0]                  frames_dropped
);

  typedef enum logic [2:0] {IDLE, START, RUN, DONE, RECOVER} state_t;

  localparam int CNT_MAX = (TIMEOUT_CYCLES > RECOVER_CYCLES) ? TIMEOUT_CYCLES : RECOVER_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [NUM_CROPS-1:0] ALL_DONE = '1;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cyc_cnt;
  logic [NUM_CROPS-1:0] mask, mask_set;
  logic                 commit_pending, commit_now, timeout_set;
  logic [COORD_W-1:0]   shadow_x [NUM_CROPS];
  logic [COORD_W-1:0]   shadow_y [NUM_CROPS];
  logic [COORD_W-1:0]   shadow_x_nxt [NUM_CROPS];
  logic [COORD_W-1:0]   shadow_y_nxt [NUM_CROPS];
  logic [COORD_W-1:0]   active_x [NUM_CROPS];
  logic [COORD_W-1:0]   active_y [NUM_CROPS];

  // Out-of-range indices match no slot, so they fall through harmlessly.
  always_comb begin
    mask_set = '0;
    for (int i = 0; i < NUM_CROPS; i++) begin
      if (res_valid && res_idx == IDX_W'(i)) mask_set[i] = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CROPS; i++) begin
      shadow_x_nxt[i] = shadow_x[i];
      shadow_y_nxt[i] = shadow_y[i];
      if (cfg_wr_en && cfg_wr_idx == IDX_W'(i)) begin
        shadow_x_nxt[i] = cfg_wr_x;
        shadow_y_nxt[i] = cfg_wr_y;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    timeout_set   = 1'b0;
    pipe_ap_start = 1'b0;
    pipe_rst      = 1'b0;
    frame_done    = 1'b0;
    busy          = (state != IDLE);
    case (state)
      IDLE:    if (frame_sof) state_nxt = START;
      START: begin
        pipe_ap_start = 1'b1;
        state_nxt     = RUN;
      end
      RUN: begin
        if ((mask | mask_set) == ALL_DONE) begin
          state_nxt = DONE;
        end else if (cyc_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_nxt   = RECOVER;
          timeout_set = 1'b1;
        end
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      RECOVER: begin
        pipe_rst = 1'b1;
        if (cyc_cnt == CNT_W'(RECOVER_CYCLES - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Active set only moves on edges that land in IDLE or START, so it is frozen through START/RUN/DONE.
  assign commit_now = (cfg_commit || commit_pending) && (state_nxt == IDLE || state_nxt == START);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cyc_cnt        <= '0;
      mask           <= '0;
      commit_pending <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      state          <= state_nxt;
      if (state_nxt != state) cyc_cnt <= '0;
      else if (state == RUN || state == RECOVER) cyc_cnt <= cyc_cnt + 1'b1;
      mask           <= (state == RUN && state_nxt == RUN) ? (mask | mask_set) : '0;
      commit_pending <= commit_now ? 1'b0 : (commit_pending | cfg_commit);
      timeout_err    <= timeout_set | (timeout_err & ~err_clear);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CROPS; i++) begin
        shadow_x[i] <= '0;
        shadow_y[i] <= '0;
        active_x[i] <= '0;
        active_y[i] <= '0;
      end
    end else begin
      shadow_x <= shadow_x_nxt;
      shadow_y <= shadow_y_nxt;
      if (commit_now) begin
        active_x <= shadow_x_nxt;
        active_y <= shadow_y_nxt;
      end
    end
  end

  for (genvar g = 0; g < NUM_CROPS; g++) begin : g_pack
    assign crop_x0[g*COORD_W +: COORD_W] = active_x[g];
    assign crop_y0[g*COORD_W +: COORD_W] = active_y[g];
  end

`ifdef RHEED_SCHED_STATS_EN
  logic [31:0] started_q, dropped_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      started_q <= '0;
      dropped_q <= '0;
    end else begin
      if (frame_sof && state == IDLE) started_q <= started_q + 32'd1;
      if (frame_sof && state != IDLE) dropped_q <= dropped_q + 32'd1;
    end
  end

  assign frames_started = started_q;
  assign frames_dropped = dropped_q;
`else
  assign frames_started = '0;
  assign frames_dropped = '0;
`endif

endmodule

// File: tb/tb_rheed_frame_sched.sv
// Bench for rheed_frame_sched: directed frame scenarios plus random traffic against a frame-level reference model.
module tb_rheed_frame_sched;

  localparam int NC = 5;
  localparam int CW = 11;
  localparam int TO = 50;
  localparam int RC = 16;
`ifdef RHEED_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          cfg_wr_en, cfg_commit, frame_sof, res_valid, err_clear;
  logic [2:0]    cfg_wr_idx, res_idx;
  logic [CW-1:0] cfg_wr_x, cfg_wr_y;
  logic [NC*CW-1:0] crop_x0, crop_y0;
  logic          pipe_ap_start, pipe_rst, busy, frame_done, timeout_err;
  logic [31:0]   frames_started, frames_dropped;

  int checks = 0;
  int errors = 0;
  int obs_start = 0, obs_done = 0, obs_rst = 0;

  rheed_frame_sched #(
    .NUM_CROPS(NC), .COORD_W(CW), .TIMEOUT_CYCLES(TO), .RECOVER_CYCLES(RC)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_wr_en(cfg_wr_en), .cfg_commit(cfg_commit), .frame_sof(frame_sof),
    .res_valid(res_valid), .err_clear(err_clear),
    .cfg_wr_idx(cfg_wr_idx), .cfg_wr_x(cfg_wr_x), .cfg_wr_y(cfg_wr_y), .res_idx(res_idx),
    .crop_x0(crop_x0), .crop_y0(crop_y0),
    .pipe_ap_start(pipe_ap_start), .pipe_rst(pipe_rst), .busy(busy),
    .frame_done(frame_done), .timeout_err(timeout_err),
    .frames_started(frames_started), .frames_dropped(frames_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: frame phase 0 idle, 1 start, 2 run, 3 done, 4 recover.
  int                     m_phase;
  logic [NC-1:0]          m_got;
  int                     m_age, m_rec_left;
  logic [NC-1:0][CW-1:0]  m_sx, m_sy, m_ax, m_ay;
  bit                     m_pend, m_err;
  int unsigned            m_started, m_dropped;

  task automatic model_init();
    m_phase = 0; m_got = '0; m_age = 0; m_rec_left = 0;
    m_sx = '0; m_sy = '0; m_ax = '0; m_ay = '0;
    m_pend = 0; m_err = 0; m_started = 0; m_dropped = 0;
  endtask

  task automatic model_step();
    int nxt;
    bit set_err;
    nxt = m_phase;
    set_err = 0;
    if (frame_sof && m_phase != 0) m_dropped++;
    if (cfg_wr_en && cfg_wr_idx < NC) begin
      m_sx[cfg_wr_idx] = cfg_wr_x;
      m_sy[cfg_wr_idx] = cfg_wr_y;
    end
    if (cfg_commit) m_pend = 1;
    case (m_phase)
      0: if (frame_sof) begin nxt = 1; m_started++; end
      1: begin nxt = 2; m_age = 0; m_got = '0; end
      2: begin
        if (res_valid && res_idx < NC) m_got[res_idx] = 1'b1;
        if (m_got == {NC{1'b1}}) nxt = 3;
        else if (m_age == TO - 1) begin nxt = 4; set_err = 1; m_rec_left = RC; end
        else m_age++;
      end
      3: nxt = 0;
      default: begin
        m_rec_left--;
        if (m_rec_left == 0) nxt = 0;
      end
    endcase
    if (set_err) m_err = 1;
    else if (err_clear) m_err = 0;
    if (m_pend && (nxt == 0 || nxt == 1)) begin
      m_ax = m_sx; m_ay = m_sy; m_pend = 0;
    end
    m_phase = nxt;
  endtask

  initial begin
    model_init();
    forever begin
      @(posedge clk);
      if (reset) model_init();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        obs_start += int'(pipe_ap_start);
        obs_done  += int'(frame_done);
        obs_rst   += int'(pipe_rst);
        chk("busy", busy, m_phase != 0);
        chk("pipe_ap_start", pipe_ap_start, m_phase == 1);
        chk("frame_done", frame_done, m_phase == 3);
        chk("pipe_rst", pipe_rst, m_phase == 4);
        chk("timeout_err", timeout_err, m_err);
        chk("crop_x0", crop_x0, m_ax);
        chk("crop_y0", crop_y0, m_ay);
        chk("frames_started", frames_started, STATS ? m_started : 0);
        chk("frames_dropped", frames_dropped, STATS ? m_dropped : 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cfg_wr_en = 0; cfg_commit = 0; frame_sof = 0; res_valid = 0; err_clear = 0;
    cfg_wr_idx = 0; cfg_wr_x = 0; cfg_wr_y = 0; res_idx = 0;
  endtask

  task automatic start_frame();
    frame_sof = 1; tick();
    frame_sof = 0; tick();
  endtask

  task automatic send_results(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      res_valid = 1; res_idx = 3'(i); tick();
    end
    res_valid = 0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin tick(); n++; end
    chk("wait_idle_bound", busy, 0);
  endtask

  initial begin
    int b_start, b_done, b_rst;
    reset = 1;
    clear_inputs();
    repeat (3) tick();
    reset = 0;
    chk("reset_busy", busy, 0);
    chk("reset_crop_x0", crop_x0, 0);
    chk("reset_timeout_err", timeout_err, 0);
    chk("reset_started", frames_started, 0);

    // Write slot 2 and commit in IDLE.
    cfg_wr_en = 1; cfg_wr_idx = 2; cfg_wr_x = 100; cfg_wr_y = 40; cfg_commit = 1;
    tick();
    clear_inputs();
    chk("idle_commit_x2", crop_x0[2*CW +: CW], 100);
    chk("idle_commit_y2", crop_y0[2*CW +: CW], 40);

    // Full frame, results 0..4 one per cycle.
    b_start = obs_start;
    frame_sof = 1; tick(); frame_sof = 0;
    chk("start_pulse", pipe_ap_start, 1);
    tick();
    send_results(0, 3);
    res_valid = 1; res_idx = 4;
    chk("no_done_before_last", frame_done, 0);
    tick(); res_valid = 0;
    chk("done_after_last", frame_done, 1);
    tick();
    chk("one_start_pulse", obs_start - b_start, 1);
    chk("started_after_frame1", frames_started, STATS ? 1 : 0);
    chk("idle_after_done", busy, 0);

    // Commit during RUN is held until the next IDLE.
    start_frame();
    cfg_wr_en = 1; cfg_wr_idx = 0; cfg_wr_x = 7; cfg_wr_y = 3; cfg_commit = 1;
    tick();
    clear_inputs();
    chk("run_commit_held", crop_x0[CW-1:0], 0);
    send_results(0, 4);
    chk("done_commit_held", crop_x0[CW-1:0], 0);
    tick();
    chk("idle_commit_applied_x", crop_x0[CW-1:0], 7);
    chk("idle_commit_applied_y", crop_y0[CW-1:0], 3);

    // Second frame_sof three cycles after the first is dropped.
    b_start = obs_start;
    frame_sof = 1; tick(); frame_sof = 0;
    tick(); tick();
    frame_sof = 1; tick(); frame_sof = 0;
    send_results(0, 4);
    tick();
    chk("drop_count", frames_dropped, STATS ? 1 : 0);
    chk("drop_one_start", obs_start - b_start, 1);
    chk("started_after_frame3", frames_started, STATS ? 3 : 0);

    // Missing result 4 -> timeout and recovery.
    b_done = obs_done; b_rst = obs_rst;
    start_frame();
    send_results(0, 3);
    wait_idle(200);
    chk("timeout_flag", timeout_err, 1);
    chk("recover_len", obs_rst - b_rst, RC);
    chk("timeout_no_done", obs_done - b_done, 0);
    err_clear = 1; tick(); err_clear = 0;
    chk("err_cleared", timeout_err, 0);

    // Duplicate index never completes the frame.
    b_done = obs_done;
    start_frame();
    send_results(1, 1);
    send_results(1, 1);
    send_results(0, 0);
    send_results(2, 3);
    wait_idle(200);
    chk("dup_no_done", obs_done - b_done, 0);
    chk("dup_timeout", timeout_err, 1);
    chk("started_total", frames_started, STATS ? 5 : 0);
    chk("dropped_total", frames_dropped, STATS ? 1 : 0);

    // Random traffic, including occasional mid-frame resets.
    for (int c = 0; c < 3000; c++) begin
      frame_sof  = ($urandom_range(0, 19) == 0);
      res_valid  = $urandom_range(0, 1) == 1;
      res_idx    = 3'($urandom_range(0, 7));
      cfg_wr_en  = ($urandom_range(0, 4) == 0);
      cfg_wr_idx = 3'($urandom_range(0, 7));
      cfg_wr_x   = CW'($urandom);
      cfg_wr_y   = CW'($urandom);
      cfg_commit = ($urandom_range(0, 15) == 0);
      err_clear  = ($urandom_range(0, 31) == 0);
      reset      = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset = 0;
    clear_inputs();
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rheed_frame_sched.md
RHEED_FRAME_SCHED -- requirements
Module: rheed_frame_sched

Interface
REQ-001 SHALL have parameter NUM_CROPS, default 5, number of crop windows per frame.
REQ-002 SHALL have parameter COORD_W, default 11, crop-coordinate width in bits.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000, maximum cycles from pipeline start to last crop result.
REQ-004 SHALL have parameter RECOVER_CYCLES, default 16, pipeline soft-reset pulse length.
REQ-005 SHALL have port clk  input  1  clock.
REQ-006 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have ports cfg_wr_en, cfg_commit, frame_sof, res_valid, err_clear  input  1  config write strobe, shadow-to-active commit, camera start-of-frame pulse, crop-result strobe, sticky-error clear.
REQ-008 SHALL have ports cfg_wr_idx  input  clog2(NUM_CROPS)  crop slot; cfg_wr_x, cfg_wr_y  input  COORD_W  shadow x0/y0 data; res_idx  input  clog2(NUM_CROPS)  index of returned result.
REQ-009 SHALL have ports crop_x0, crop_y0  output  NUM_CROPS*COORD_W  active coordinates, slot i at bits [i*COORD_W +: COORD_W].
REQ-010 SHALL have ports pipe_ap_start, pipe_rst, busy, frame_done, timeout_err  output  1  pipeline start pulse, pipeline soft reset, frame in flight, all-crops-done pulse, sticky timeout flag.
REQ-011 SHALL have ports frames_started, frames_dropped  output  32  statistics counters.

Function
REQ-012 SHALL implement FSM states IDLE, START, RUN, DONE, RECOVER.
REQ-013 IDLE: frame_sof -> START; no other exit.
REQ-014 START: one cycle; pipe_ap_start=1 for exactly this cycle; pending commit applied on entry; -> RUN.
REQ-015 RUN: res_valid sets bit res_idx of a NUM_CROPS-bit result mask; a repeated index is ignored; res_idx >= NUM_CROPS is ignored.
REQ-016 RUN: when all mask bits are set (including by the current strobe) -> DONE next cycle.
REQ-017 DONE: frame_done=1 for one cycle; mask cleared; -> IDLE.
REQ-018 RUN: cycle counter starts at 0 on entering RUN; reaching TIMEOUT_CYCLES-1 without completion -> RECOVER, timeout_err set.
REQ-019 RECOVER: pipe_rst=1 for exactly RECOVER_CYCLES cycles; mask cleared; -> IDLE.
REQ-020 frame_sof in START, RUN, DONE or RECOVER SHALL be dropped (frames_dropped +1), never queued.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 cfg_wr_en SHALL write shadow slot cfg_wr_idx in any state; out-of-range index ignored.
REQ-023 cfg_commit SHALL copy all shadow slots to active in the same cycle when in IDLE, else set commit_pending, applied at next START entry or next IDLE entry, whichever first.
REQ-024 cfg_wr_en and cfg_commit in the same IDLE cycle SHALL commit the newly written value.
REQ-025 crop_x0/crop_y0 SHALL never change in START, RUN or DONE.
REQ-026 frames_started SHALL increment on each START entry; both counters wrap at 2^32.
REQ-027 err_clear SHALL clear timeout_err; simultaneous set and clear -> set wins.

Reset
REQ-028 reset SHALL force IDLE, clear mask, commit_pending, counters and timeout_err; pipe_ap_start, pipe_rst, busy, frame_done = 0.
REQ-029 reset SHALL set shadow and active coordinates to 0.
REQ-030 reset asserted mid-RUN SHALL abandon the frame without a frame_done pulse or drop count.

Configuration
REQ-031 Macro RHEED_SCHED_STATS_EN: defined -> frames_started/frames_dropped per REQ-020/026; undefined -> both outputs tied 0, no counter registers.

Verification
REQ-032 Write slot2 x=100,y=40, commit in IDLE -> crop_x0 slot2=100, crop_y0 slot2=40 next cycle.
REQ-033 frame_sof, then res_idx 0..4 one per cycle -> one pipe_ap_start pulse, frame_done 1 cycle after idx4, frames_started=1.
REQ-034 Commit during RUN with slot0 shadow x=7 -> active slot0 unchanged until IDLE, then 7.
REQ-035 Two frame_sof 3 cycles apart -> second dropped, frames_dropped=1, one pipe_ap_start.
REQ-036 TIMEOUT_CYCLES=50, results 0..3 only -> timeout_err=1, pipe_rst high 16 cycles, IDLE, no frame_done.
REQ-037 Duplicate res_idx 1 twice, idx 4 never -> no frame_done; stats-off build -> counters read 0.
